// File: rtl/instr_mem_loader_if.sv
// Handshake, control and memory write-port signals of the instruction memory loader.
// master = byte source / boot controller side, slave = loader side.
interface instr_mem_loader_if;
   logic        start;
   logic [15:0] len_words;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        core_rst;

   modport master (
      output start, len_words, byte_valid, byte_data,
      input  byte_ready, we, waddr, wdata, busy, done, err, core_rst
   );

   modport slave (
      input  start, len_words, byte_valid, byte_data,
      output byte_ready, we, waddr, wdata, busy, done, err, core_rst
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time loader: packs a byte stream into little-endian words, writes them to
// instruction memory and holds the core in reset until the load completes.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RECV    | accepting bytes of the current word
// WRITE   | one-cycle write strobe for the assembled word
// DONE    | load complete, core released
// ERR     | requested length does not fit in memory, core held
module instr_mem_loader #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned BASE_ADDR = 0
) (
   input logic               clk,
   input logic               rst,
   instr_mem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // 33-bit so neither the limit nor len*4 can wrap for any legal parameter set
   localparam logic [32:0] LIMIT = 33'(MEM_BYTES) - 33'(BASE_ADDR);

   state_t      state;
   logic [15:0] len_q;
   logic [15:0] word_cnt;
   logic [1:0]  byte_cnt;
   logic [23:0] buffer;
   logic [32:0] req_bytes;

   assign req_bytes = {15'd0, bus.len_words, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         len_q          <= '0;
         word_cnt       <= '0;
         byte_cnt       <= '0;
         buffer         <= '0;
         bus.byte_ready <= 1'b0;
         bus.we         <= 1'b0;
         bus.waddr      <= '0;
         bus.wdata      <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
         bus.core_rst   <= 1'b1;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  if (bus.len_words == 16'd0) begin
                     state        <= S_DONE;
                     bus.done     <= 1'b1;
                     bus.core_rst <= 1'b0;
                  end else if (req_bytes > LIMIT) begin
                     state        <= S_ERR;
                     bus.err      <= 1'b1;
                     bus.done     <= 1'b0;
                     bus.core_rst <= 1'b1;
                  end else begin
                     state          <= S_RECV;
                     len_q          <= bus.len_words;
                     word_cnt       <= '0;
                     byte_cnt       <= '0;
                     bus.done       <= 1'b0;
                     bus.err        <= 1'b0;
                     bus.core_rst   <= 1'b1;
                     bus.busy       <= 1'b1;
                     bus.byte_ready <= 1'b1;
                  end
               end
            end

            S_RECV: begin
               if (bus.byte_valid && bus.byte_ready) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0:    buffer[7:0]   <= bus.byte_data;
                     2'd1:    buffer[15:8]  <= bus.byte_data;
                     2'd2:    buffer[23:16] <= bus.byte_data;
                     default: buffer        <= buffer;
                  endcase
                  // fourth byte goes straight into wdata, the buffer only holds lanes 0..2
                  if (byte_cnt == 2'd3) begin
                     state          <= S_WRITE;
                     bus.we         <= 1'b1;
                     bus.waddr      <= 32'(BASE_ADDR) + {14'd0, word_cnt, 2'b00};
                     bus.wdata      <= {bus.byte_data, buffer};
                     bus.byte_ready <= 1'b0;
                  end
               end
            end

            S_WRITE: begin
               bus.we   <= 1'b0;
               word_cnt <= word_cnt + 16'd1;
               if (word_cnt + 16'd1 == len_q) begin
                  state        <= S_DONE;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.core_rst <= 1'b0;
               end else begin
                  state          <= S_RECV;
                  bus.byte_ready <= 1'b1;
               end
            end

            default: begin
               state          <= S_IDLE;
               bus.byte_ready <= 1'b0;
               bus.we         <= 1'b0;
               bus.busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected writes are queued as bytes
// are driven and matched by a monitor whenever the write strobe fires.
module tb_instr_mem_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_mem_loader_if bus ();

   instr_mem_loader #(
      .MEM_BYTES(1024),
      .BASE_ADDR(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   always @(posedge clk) cyc++;

   // write monitor / scoreboard
   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got waddr=%h wdata=%h, required no write", bus.waddr, bus.wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.waddr, bus.wdata} !== mon_e) begin
               n_fail++;
               $display("FAIL write_data: got %h@%h, required %h@%h", bus.wdata, bus.waddr, mon_e[31:0], mon_e[63:32]);
            end
         end
         n_checks++;
         if (bus.byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_write: got byte_ready=%b, required 0", bus.byte_ready);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic start_load(input logic [15:0] len);
      bus.start     = 1'b1;
      bus.len_words = len;
      start_cyc     = cyc;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) begin
         bus.byte_valid = 1'b0;
         @(negedge clk);
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      t = 0;
      while (bus.byte_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 50) begin
         n_fail++;
         $display("FAIL byte_accept_timeout: got byte_ready=%b after %0d cycles, required 1", bus.byte_ready, t);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, input logic [31:0] addr);
      exp_q.push_back({addr, w});
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic wait_done(output int lat);
      int t;
      t = 0;
      while (bus.done !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      lat = cyc - start_cyc;
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timeout: got done=%b, required 1", bus.done);
      end
   endtask

   task automatic check_queue_empty(input string name);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.len_words  = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.byte_ready, bus.we, bus.busy, bus.done, bus.err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got ready/we/busy/done/err=%b, required 00000",
                  {bus.byte_ready, bus.we, bus.busy, bus.done, bus.err});
      end
      n_checks++;
      if ({bus.waddr, bus.wdata} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got waddr=%h wdata=%h, required 0", bus.waddr, bus.wdata);
      end
      n_checks++;
      if (bus.core_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_core_rst: got %b, required 1", bus.core_rst);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      start_load(16'd2);
      send_word(32'h0000_0013, 0, 32'h0);
      send_word(32'h0010_0093, 0, 32'h4);
      wait_done(lat);
      n_checks++;
      if (lat != 11) begin
         n_fail++;
         $display("FAIL b2b_done_latency: got %0d cycles, required 11", lat);
      end
      n_checks++;
      if ({bus.core_rst, bus.busy, bus.err} !== 3'b000) begin
         n_fail++;
         $display("FAIL b2b_done_outputs: got core_rst/busy/err=%b, required 000", {bus.core_rst, bus.busy, bus.err});
      end
      check_queue_empty("b2b_writes");
   endtask

   task automatic test_stall();
      int lat;
      start_load(16'd2);
      send_word(32'h0000_0013, 3, 32'h0);
      send_word(32'h0010_0093, 3, 32'h4);
      wait_done(lat);
      n_checks++;
      if (bus.core_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_core_rst: got %b, required 0", bus.core_rst);
      end
      check_queue_empty("stall_writes");
   endtask

   task automatic test_len_error();
      int lat;
      start_load(16'd257);
      n_checks++;
      if ({bus.err, bus.core_rst, bus.busy, bus.done} !== 4'b1100) begin
         n_fail++;
         $display("FAIL len_err_outputs: got err/core_rst/busy/done=%b, required 1100",
                  {bus.err, bus.core_rst, bus.busy, bus.done});
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL len_err_sticky: got err=%b, required 1", bus.err);
      end
      start_load(16'd1);
      n_checks++;
      if ({bus.err, bus.busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL err_clear: got err/busy=%b, required 01", {bus.err, bus.busy});
      end
      send_word(32'hDEAD_BEEF, 0, 32'h0);
      wait_done(lat);
      check_queue_empty("err_recover_write");
      // largest length that still fits
      start_load(16'd256);
      n_checks++;
      if ({bus.err, bus.busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL len_256_accept: got err/busy=%b, required 01", {bus.err, bus.busy});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_midword();
      int lat;
      start_load(16'd2);
      send_word(32'h1122_3344, 0, 32'h0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({bus.busy, bus.byte_ready, bus.core_rst} !== 3'b001) begin
         n_fail++;
         $display("FAIL midword_reset: got busy/ready/core_rst=%b, required 001",
                  {bus.busy, bus.byte_ready, bus.core_rst});
      end
      repeat (3) @(negedge clk);
      check_queue_empty("midword_first_word");
      start_load(16'd1);
      send_word(32'hDDCC_BBAA, 0, 32'h0);
      wait_done(lat);
      check_queue_empty("midword_reload");
   endtask

   task automatic test_len_zero_and_ignored_start();
      int lat;
      start_load(16'd0);
      n_checks++;
      if ({bus.done, bus.core_rst, bus.busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL len_zero: got done/core_rst/busy=%b, required 100", {bus.done, bus.core_rst, bus.busy});
      end
      start_load(16'd2);
      exp_q.push_back({32'h0, 32'hA3A2_A1A0});
      send_byte(8'hA0, 0);
      send_byte(8'hA1, 0);
      bus.start     = 1'b1;
      bus.len_words = 16'd1;
      @(negedge clk);
      bus.start     = 1'b0;
      n_checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         n_fail++;
         $display("FAIL start_ignored: got busy/done=%b, required 10", {bus.busy, bus.done});
      end
      send_byte(8'hA2, 0);
      send_byte(8'hA3, 0);
      send_word(32'hB3B2_B1B0, 0, 32'h4);
      wait_done(lat);
      check_queue_empty("ignored_start_writes");
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_len_error();
      test_reset_midword();
      test_len_zero_and_ignored_start();
      repeat (5) @(negedge clk);
      check_queue_empty("final_queue");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
